// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target register file.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_PTR,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_BYTE,
        ST_RD_ACK,
        ST_IGNORE
    } i2c_tgt_state_t;

    localparam logic       I2C_ACK                 = 1'b0;
    localparam logic       I2C_NACK                = 1'b1;
    localparam logic [6:0] I2C_DEFAULT_TARGET_ADDR = 7'h2A;

endpackage

// File: rtl/i2c_line_cond.sv
// SCL/SDA synchronizer, optional 3-sample majority filter (I2C_TARGET_GLITCH_FILTER_EN)
// and registered SCL edge / START / STOP detection.
module i2c_line_cond (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic sda_s,
    output logic start_det,
    output logic stop_det
);

    logic [1:0] scl_sync, sda_sync;
    logic       scl_c, sda_c, scl_d, sda_d;

    // Idle bus level is high; resetting to 1 avoids a phantom edge at reset release.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], scl_in};
            sda_sync <= {sda_sync[0], sda_in};
        end
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    logic [2:0] scl_h, sda_h;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_h <= 3'b111;
            sda_h <= 3'b111;
        end else begin
            scl_h <= {scl_h[1:0], scl_sync[1]};
            sda_h <= {sda_h[1:0], sda_sync[1]};
        end
    end

    assign scl_c = (scl_h[0] & scl_h[1]) | (scl_h[0] & scl_h[2]) | (scl_h[1] & scl_h[2]);
    assign sda_c = (sda_h[0] & sda_h[1]) | (sda_h[0] & sda_h[2]) | (sda_h[1] & sda_h[2]);
`else
    assign scl_c = scl_sync[1];
    assign sda_c = sda_sync[1];
`endif

    // sda_d is the SDA sample aligned with the registered SCL edge flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_d     <= 1'b1;
            sda_d     <= 1'b1;
            scl_rise  <= 1'b0;
            scl_fall  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
        end else begin
            scl_d     <= scl_c;
            sda_d     <= sda_c;
            scl_rise  <= scl_c & ~scl_d;
            scl_fall  <= ~scl_c & scl_d;
            start_det <= scl_c & scl_d & sda_d & ~sda_c;
            stop_det  <= scl_c & scl_d & ~sda_d & sda_c;
        end
    end

    assign sda_s = sda_d;

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target exposing a REG_DEPTH x 8 register file; never stretches SCL.
// Optional input glitch filter: I2C_TARGET_GLITCH_FILTER_EN (see i2c_line_cond).
module i2c_target_regfile
    import i2c_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = I2C_DEFAULT_TARGET_ADDR,
    parameter int         REG_DEPTH   = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         scl_in,
    input  logic                         sda_in,
    output logic                         sda_pull_low,
    input  logic [$clog2(REG_DEPTH)-1:0] local_addr,
    output logic [7:0]                   local_rdata,
    output logic                         wr_strobe,
    output logic [$clog2(REG_DEPTH)-1:0] wr_addr,
    output logic                         busy
);

    localparam int AW = $clog2(REG_DEPTH);

    logic           scl_rise, scl_fall, sda_s, start_det, stop_det;
    i2c_tgt_state_t state;
    logic [7:0]     shreg, rx_byte;
    logic [2:0]     bitcnt;
    logic           phase, rw;
    logic [AW-1:0]  ptr;
    logic [7:0]     regs [REG_DEPTH];

    i2c_line_cond u_cond (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .sda_s     (sda_s),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    assign rx_byte     = {shreg[6:0], sda_s};
    assign local_rdata = regs[local_addr];

    always_ff @(posedge clk) begin
        wr_strobe <= 1'b0;
        if (!rst_n) begin
            state        <= ST_IDLE;
            shreg        <= '0;
            bitcnt       <= '0;
            phase        <= 1'b0;
            rw           <= 1'b0;
            ptr          <= '0;
            sda_pull_low <= 1'b0;
            wr_addr      <= '0;
            busy         <= 1'b0;
            for (int i = 0; i < REG_DEPTH; i++) regs[i] <= '0;
        end else if (stop_det) begin
            state        <= ST_IDLE;
            sda_pull_low <= 1'b0;
            busy         <= 1'b0;
        end else if (start_det) begin
            state        <= ST_ADDR;
            bitcnt       <= '0;
            sda_pull_low <= 1'b0;
            busy         <= 1'b1;
        end else begin
            case (state)
                // bitcnt wraps back to 0 on the 8th bit, ready for the next byte
                ST_ADDR, ST_WR_PTR, ST_WR_DATA: if (scl_rise) begin
                    shreg  <= rx_byte;
                    bitcnt <= bitcnt + 3'd1;
                    if (bitcnt == 3'd7) begin
                        phase <= 1'b0;
                        if (state == ST_ADDR) begin
                            rw    <= rx_byte[0];
                            state <= (rx_byte[7:1] == TARGET_ADDR) ? ST_ADDR_ACK : ST_IGNORE;
                        end else if (state == ST_WR_PTR) begin
                            ptr   <= rx_byte[AW-1:0];
                            state <= ST_WR_ACK;
                        end else begin
                            regs[ptr] <= rx_byte;
                            wr_strobe <= 1'b1;
                            wr_addr   <= ptr;
                            ptr       <= ptr + AW'(1);
                            state     <= ST_WR_ACK;
                        end
                    end
                end
                // First fall starts the ACK bit, second fall ends it.
                ST_ADDR_ACK, ST_WR_ACK: if (scl_fall) begin
                    if (!phase) begin
                        phase        <= 1'b1;
                        sda_pull_low <= ~I2C_ACK;
                    end else begin
                        phase <= 1'b0;
                        if (state == ST_ADDR_ACK && rw) begin
                            shreg        <= regs[ptr];
                            sda_pull_low <= ~regs[ptr][7];
                            bitcnt       <= '0;
                            state        <= ST_RD_BYTE;
                        end else begin
                            sda_pull_low <= 1'b0;
                            state        <= (state == ST_ADDR_ACK) ? ST_WR_PTR : ST_WR_DATA;
                        end
                    end
                end
                ST_RD_BYTE: if (scl_fall) begin
                    bitcnt <= bitcnt + 3'd1;
                    shreg  <= {shreg[6:0], 1'b0};
                    if (bitcnt == 3'd7) begin
                        sda_pull_low <= 1'b0;
                        ptr          <= ptr + AW'(1);
                        phase        <= 1'b0;
                        state        <= ST_RD_ACK;
                    end else begin
                        sda_pull_low <= ~shreg[6];
                    end
                end
                // phase holds the master's NACK from the rising edge
                ST_RD_ACK: begin
                    if (scl_rise) phase <= (sda_s == I2C_NACK);
                    if (scl_fall) begin
                        if (phase) begin
                            state <= ST_IGNORE;
                        end else begin
                            shreg        <= regs[ptr];
                            sda_pull_low <= ~regs[ptr][7];
                            bitcnt       <= '0;
                            state        <= ST_RD_BYTE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/i2c_target_regfile.md
# i2c_target_regfile

I2C target (responder) that answers the transactions issued by the team's I2C master over the shared SCL/SDA lines. It exposes a 16×8 register file to the I2C bus and a read/status port to local logic. It is the far end of the APB-to-I2C path: APB writes reach the I2C master, and the I2C master reaches this block. SCL and SDA are oversampled on the system clock. The block never stretches SCL.

## Interface
Parameters:
- TARGET_ADDR, 7'h2A: 7-bit I2C address this target answers to.
- REG_DEPTH, 16: number of 8-bit registers. Must be a power of 2, at most 256.

Ports:
- clk, input, 1: system clock. Must run at least 8× SCL.
- rst_n, input, 1: reset, synchronous, active-low.
- scl_in, input, 1: SCL line level, asynchronous.
- sda_in, input, 1: SDA line level, asynchronous.
- sda_pull_low, output, 1: 1 drives SDA low (open-drain). 0 releases SDA.
- local_addr, input, $clog2(REG_DEPTH): local read address.
- local_rdata, output, 8: register[local_addr], combinational.
- wr_strobe, output, 1: one-cycle pulse when the I2C side writes a register.
- wr_addr, output, $clog2(REG_DEPTH): address of the last I2C write.
- busy, output, 1: 1 from START until STOP.

## Operation
- Input conditioning:
  - scl_in and sda_in each pass through a 2-flop synchronizer.
  - Rising and falling edges of SCL are detected by comparing against the previous sample.
- Bus conditions:
  - START / repeated START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Both are detected in every state and take priority over data handling.
- Data sampling: SDA is sampled on SCL rising edges, MSB first.
- SDA driving: sda_pull_low changes only in the cycle after a detected SCL falling edge.
- State machine:
  - IDLE → ADDR on START.
  - ADDR: shift in 8 bits (address[6:0] + R/W).
    - On an address match → ADDR_ACK.
    - On a mismatch → IGNORE. SDA stays released.
  - ADDR_ACK: pull SDA low for one SCL period.
    - R/W=0 → WR_PTR.
    - R/W=1 → RD_BYTE.
  - WR_PTR: receive one byte. ptr = byte mod REG_DEPTH. → WR_ACK.
  - WR_DATA: receive one byte. Write reg[ptr], pulse wr_strobe, set wr_addr=ptr, then ptr=ptr+1 (wraps at REG_DEPTH). → WR_ACK.
  - WR_ACK: drive ACK for one SCL period. → WR_DATA.
  - RD_BYTE: load reg[ptr] at entry. Drive bit 7 first; drive 0 bits with sda_pull_low=1 and 1 bits released. After the 8th falling edge, release SDA, then ptr=ptr+1. → RD_ACK.
  - RD_ACK: sample the master's ACK bit.
    - ACK (0) → RD_BYTE.
    - NACK (1) → IGNORE.
  - IGNORE: wait for START or STOP. SDA released.
  - Any state → IDLE on STOP. Any state → ADDR on repeated START.
- Pointer: ptr persists across transactions, so a write of the pointer alone followed by a repeated-START read returns reg[ptr].
- Collision: if the same cycle sees both an SCL edge and START/STOP, START/STOP wins.

## Timing
- Reset values:
  - sda_pull_low=0, wr_strobe=0, wr_addr=0, busy=0.
  - All registers=0, ptr=0, state=IDLE.
- Detection latency: 3 clk from a pin change to the detected edge or condition (2 sync flops + 1 edge register).
- wr_strobe asserts 1 clk after the 8th data-bit SCL rise is detected.
- local_rdata reflects a write on the clk after wr_strobe.
- Reset mid-transfer: SDA is released the next cycle and state returns to IDLE. The bus master sees NACK or lost data, which is acceptable.

## Configuration
- I2C_TARGET_GLITCH_FILTER_EN:
  - Defined: each synchronized line passes through a 3-sample majority filter before edge detection. This adds 2 clk of detection latency (total 5) and rejects single-cycle pulses.
  - Undefined: no filter. Latency is 3 clk, and a 1-clk glitch is treated as a real edge.

## Structure
- Package i2c_pkg holds:
  - the state enum typedef i2c_tgt_state_t;
  - the ACK/NACK bit constants;
  - the default target address constant.
- Sub-module i2c_line_cond does synchronization, the optional filter and edge/START/STOP detection. It outputs scl_rise, scl_fall, sda_s, start_det and stop_det.
- Top-level block: FSM, shift register, pointer, register file.

## Test plan
- Single write: START, 0x54 (addr 0x2A write), 0x03, 0xA5, STOP. Expect three ACKs, reg[3]=0xA5, one wr_strobe with wr_addr=3, busy low after STOP.
- Read via repeated START: START, 0x54, 0x03, Sr, 0x55, master reads two bytes (ACK, then NACK) with reg[3]=0xA5 and reg[4]=0x5A. Expect bytes 0xA5 then 0x5A, ptr=5.
- Address mismatch: START, 0x56, 0x01, STOP. Expect SDA never pulled and no wr_strobe.
- Wrap-around: write pointer 0x0F, then 0x11, 0x22. Expect reg[15]=0x11, reg[0]=0x22.
- Reset mid-byte: assert rst_n=0 after 4 bits of a data byte. Expect sda_pull_low=0 next clk and a fresh transaction to complete normally.
- Glitch (filter defined): a 1-clk SCL low pulse during a data bit. Expect no bit shift and a correct received byte.
